// File: rtl/ccw_pkg.sv
// Shared types and CCW field layout for the RH20 channel command word sequencer.
package ccw_pkg;

   localparam int ADR_W_DEF = 22;
   localparam int WC_W_DEF  = 11;
   localparam int CCW_W     = 36;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DECODE = 2'd2,
      XFER   = 2'd3
   } ccw_state_e;

   // Op bits: bit0 selects data; bit1 is last (data) or jump (non-data); bit2 is reverse.
   localparam int OP_DATA_BIT = 0;
   localparam int OP_LAST_BIT = 1;
   localparam int OP_JUMP_BIT = 1;
   localparam int OP_REV_BIT  = 2;
   localparam int WC_LSB      = 3;
   localparam int ADR_LSB     = 14;

endpackage

// File: rtl/ccw_seq_if.sv
// CCW fetch bus between the sequencer (master) and the memory port (slave).
interface ccw_seq_if
   import ccw_pkg::*;
#(
   parameter int ADR_W = ADR_W_DEF
) ();

   // Handshake: master raises ccw_mem_req_h with ccw_mem_adr_h and holds both
   // stable until the slave answers with a one-cycle ccw_mem_ack_h carrying
   // ccw_mem_data_h; the request drops the cycle after ack.
   logic               ccw_mem_req_h;
   logic [ADR_W-1:0]   ccw_mem_adr_h;
   logic               ccw_mem_ack_h;
   logic [CCW_W-1:0]   ccw_mem_data_h;

   modport master (
      output ccw_mem_req_h,
      output ccw_mem_adr_h,
      input  ccw_mem_ack_h,
      input  ccw_mem_data_h
   );

   modport slave (
      input  ccw_mem_req_h,
      input  ccw_mem_adr_h,
      output ccw_mem_ack_h,
      output ccw_mem_data_h
   );

endinterface

// File: rtl/ccw_adr_ctr.sv
// Loadable up/down counter wrapping modulo 2^W; load has priority over step.
module ccw_adr_ctr #(
   parameter int W = 22
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         step_i,
   input  logic         down_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (step_i) begin
         cnt_d = down_i ? (cnt_q - W'(1)) : (cnt_q + W'(1));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ccw_seq.sv
// RH20 channel command word sequencer: fetches CCWs, tracks count/address, chains jumps.
// Optional macro CCW_JUMP_LIMIT_EN bounds consecutive jump CCWs to MAX_JUMPS.
module ccw_seq
   import ccw_pkg::*;
#(
   parameter int ADR_W     = ADR_W_DEF,
   parameter int WC_W      = WC_W_DEF,
   parameter int MAX_JUMPS = 2
) (
   input  logic             clk_ccw_h,
   input  logic             ch_mr_reset_h,
   input  logic             ch_start_h,
   input  logic [ADR_W-1:0] ch_start_adr_h,
   ccw_seq_if.master        mem,
   input  logic             ccl_xfer_h,
   input  logic             ccl_dev_done_h,
   output logic [ADR_W-1:0] ccw_data_adr_h,
   output logic [WC_W-1:0]  ccw_wc_h,
   output logic             ccw_wcEq0_h,
   output logic             ccw_last_h,
   output logic             ccw_reverse_h,
   output logic             ccw_xfer_valid_h,
   output logic             ccw_ccwf_waiting_h,
   output logic             ccw_done_h,
   output logic             ccw_short_wc_err_h,
   output logic             ccw_long_wc_err_h,
   output logic             ccw_jump_err_h,
   output ccw_state_e       dbg_state_o
);

   localparam int JC_W = $clog2(MAX_JUMPS + 2);

   ccw_state_e       state_q;
   logic [CCW_W-1:0] ccw_q;
   logic [WC_W-1:0]  wc_q;
   logic [WC_W-1:0]  wc_d;
   logic [JC_W-1:0]  jcnt_q;
   logic             last_q, rev_q, done_q, short_q, long_q;
   logic [ADR_W-1:0] ptr;
   logic [ADR_W-1:0] fld_adr;
   logic             op_data, op_jump, op_halt, in_decode, xfer_step;
   logic             ptr_load, ptr_step, dadr_load;

   assign op_data   = ccw_q[OP_DATA_BIT];
   assign op_jump   = !op_data && ccw_q[OP_JUMP_BIT];
   assign op_halt   = !op_data && !ccw_q[OP_JUMP_BIT];
   assign fld_adr   = ccw_q[ADR_LSB +: ADR_W];
   assign in_decode = (state_q == DECODE) && !ccl_dev_done_h;
   assign xfer_step = (state_q == XFER) && ccl_xfer_h && (wc_q != '0);
   assign wc_d      = xfer_step ? (wc_q - WC_W'(1)) : wc_q;

`ifdef CCW_JUMP_LIMIT_EN
   logic jerr_q;
   logic jump_over;
   assign jump_over      = (jcnt_q >= JC_W'(MAX_JUMPS));
   assign ccw_jump_err_h = jerr_q;
`else
   assign ccw_jump_err_h = 1'b0;
`endif

   // The fetch pointer is only ever loaded or advanced, never stepped down.
   always_comb begin
      ptr_load = (state_q == IDLE) && ch_start_h;
`ifdef CCW_JUMP_LIMIT_EN
      ptr_load = ptr_load || (in_decode && op_jump && !jump_over);
`else
      ptr_load = ptr_load || (in_decode && op_jump);
`endif
   end
   assign ptr_step  = in_decode && op_data;
   assign dadr_load = in_decode && op_data;

   ccw_adr_ctr #(.W(ADR_W)) u_ptr_ctr (
      .clk_i      (clk_ccw_h),
      .rst_i      (ch_mr_reset_h),
      .load_i     (ptr_load),
      .load_val_i ((state_q == IDLE) ? ch_start_adr_h : fld_adr),
      .step_i     (ptr_step),
      .down_i     (1'b0),
      .cnt_o      (ptr)
   );

   ccw_adr_ctr #(.W(ADR_W)) u_dadr_ctr (
      .clk_i      (clk_ccw_h),
      .rst_i      (ch_mr_reset_h),
      .load_i     (dadr_load),
      .load_val_i (fld_adr),
      .step_i     (xfer_step),
      .down_i     (rev_q),
      .cnt_o      (ccw_data_adr_h)
   );

   always_ff @(posedge clk_ccw_h) begin
      if (ch_mr_reset_h) begin
         state_q <= IDLE;
         ccw_q   <= '0;
         wc_q    <= '0;
         jcnt_q  <= '0;
         last_q  <= 1'b0;
         rev_q   <= 1'b0;
         done_q  <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
`ifdef CCW_JUMP_LIMIT_EN
         jerr_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (ch_start_h) begin
                  state_q <= FETCH;
                  jcnt_q  <= '0;
                  last_q  <= 1'b0;
                  rev_q   <= 1'b0;
                  done_q  <= 1'b0;
                  short_q <= 1'b0;
                  long_q  <= 1'b0;
`ifdef CCW_JUMP_LIMIT_EN
                  jerr_q  <= 1'b0;
`endif
               end
            end
            FETCH: begin
               if (ccl_dev_done_h) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (mem.ccw_mem_ack_h) begin
                  ccw_q   <= mem.ccw_mem_data_h;
                  state_q <= DECODE;
               end
            end
            DECODE: begin
               if (ccl_dev_done_h || op_halt) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (op_jump) begin
`ifdef CCW_JUMP_LIMIT_EN
                  if (jump_over) begin
                     jerr_q  <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     jcnt_q  <= jcnt_q + JC_W'(1);
                     state_q <= FETCH;
                  end
`else
                  if (jcnt_q != '1) begin
                     jcnt_q <= jcnt_q + JC_W'(1);
                  end
                  state_q <= FETCH;
`endif
               end else begin
                  wc_q    <= ccw_q[WC_LSB +: WC_W];
                  jcnt_q  <= '0;
                  last_q  <= ccw_q[OP_LAST_BIT];
                  rev_q   <= ccw_q[OP_REV_BIT];
                  state_q <= XFER;
               end
            end
            XFER: begin
               wc_q <= wc_d;
               if (ccl_xfer_h && (wc_q == '0)) begin
                  long_q <= 1'b1;
               end
               // Done is judged against the count after this cycle's transfer.
               if (ccl_dev_done_h) begin
                  if (wc_d != '0) begin
                     short_q <= 1'b1;
                  end
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if ((wc_q == '0) && !last_q) begin
                  state_q <= FETCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem.ccw_mem_req_h  = (state_q == FETCH);
   assign mem.ccw_mem_adr_h  = ptr;
   assign ccw_ccwf_waiting_h = (state_q == FETCH);
   assign ccw_wc_h           = wc_q;
   assign ccw_wcEq0_h        = (state_q == XFER) && (wc_q == '0);
   assign ccw_xfer_valid_h   = (state_q == XFER) && (wc_q != '0);
   assign ccw_last_h         = last_q;
   assign ccw_reverse_h      = rev_q;
   assign ccw_done_h         = done_q;
   assign ccw_short_wc_err_h = short_q;
   assign ccw_long_wc_err_h  = long_q;
   assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_ccw_seq.sv
// Directed bench for ccw_seq: cycle table for two CCW lists, then hand-written corner sequences.
module tb_ccw_seq;
  import ccw_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [21:0] sadr;
  logic        xfer;
  logic        dd;
  logic [21:0] data_adr;
  logic [10:0] wc;
  logic        eq0, last, rev, xv, waiting, done, short_err, long_err, jump_err;
  ccw_state_e  st;

  int checks = 0;
  int errors = 0;

  ccw_seq_if #(.ADR_W(22)) mem_if ();

  ccw_seq #(.ADR_W(22), .WC_W(11), .MAX_JUMPS(2)) dut (
    .clk_ccw_h          (clk),
    .ch_mr_reset_h      (rst),
    .ch_start_h         (start),
    .ch_start_adr_h     (sadr),
    .mem                (mem_if.master),
    .ccl_xfer_h         (xfer),
    .ccl_dev_done_h     (dd),
    .ccw_data_adr_h     (data_adr),
    .ccw_wc_h           (wc),
    .ccw_wcEq0_h        (eq0),
    .ccw_last_h         (last),
    .ccw_reverse_h      (rev),
    .ccw_xfer_valid_h   (xv),
    .ccw_ccwf_waiting_h (waiting),
    .ccw_done_h         (done),
    .ccw_short_wc_err_h (short_err),
    .ccw_long_wc_err_h  (long_err),
    .ccw_jump_err_h     (jump_err),
    .dbg_state_o        (st)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic [21:0] sadr;
    logic        ack;
    logic [35:0] data;
    logic        xfer;
    logic        dd;
    ccw_state_e  e_st;
    logic        e_req;
    logic [21:0] e_madr;
    logic [21:0] e_dadr;
    logic [10:0] e_wc;
    logic        e_eq0;
    logic        e_done;
    logic [2:0]  e_err;
    logic [1:0]  e_lr;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [35:0] ccw(input logic [2:0] op, input logic [10:0] cnt,
                                      input logic [21:0] adr);
    return {adr, cnt, op};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  // driver: apply inputs, step one clock, settle 1 time unit past the edge
  task automatic cyc(input logic r, input logic s, input logic [21:0] sa, input logic a,
                     input logic [35:0] d, input logic x, input logic ddn);
    rst = r;
    start = s;
    sadr = sa;
    mem_if.ccw_mem_ack_h = a;
    mem_if.ccw_mem_data_h = d;
    xfer = x;
    dd = ddn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b0, 1'b0);
  endtask

  task automatic drive(input vec_t v, input int i);
    cyc(v.rst, v.start, v.sadr, v.ack, v.data, v.xfer, v.dd);
    chk($sformatf("r%0d.state", i), 64'(st), 64'(v.e_st));
    chk($sformatf("r%0d.req", i), 64'(mem_if.ccw_mem_req_h), 64'(v.e_req));
    chk($sformatf("r%0d.waiting", i), 64'(waiting), 64'(v.e_st == FETCH));
    chk($sformatf("r%0d.mem_adr", i), 64'(mem_if.ccw_mem_adr_h), 64'(v.e_madr));
    chk($sformatf("r%0d.data_adr", i), 64'(data_adr), 64'(v.e_dadr));
    chk($sformatf("r%0d.wc", i), 64'(wc), 64'(v.e_wc));
    chk($sformatf("r%0d.wcEq0", i), 64'(eq0), 64'(v.e_eq0));
    chk($sformatf("r%0d.xfer_valid", i), 64'(xv), 64'(v.e_st == XFER && v.e_wc != 11'd0));
    chk($sformatf("r%0d.done", i), 64'(done), 64'(v.e_done));
    chk($sformatf("r%0d.errs", i), 64'({short_err, long_err, jump_err}), 64'(v.e_err));
    chk($sformatf("r%0d.last_rev", i), 64'({last, rev}), 64'(v.e_lr));
  endtask

  initial begin
    // Forward list at 0o1000 chaining into a halt, then a reverse last CCW wrapping below 0.
    tbl[0]  = '{1'b1, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b0, 1'b0,
                IDLE,   1'b0, 22'o0,    22'o0,        11'd0, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 22'o1000, 1'b0, 36'd0,                     1'b0, 1'b0,
                FETCH,  1'b1, 22'o1000, 22'o0,        11'd0, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[2]  = '{1'b0, 1'b0, 22'o0,    1'b1, ccw(3'd1, 11'd3, 22'o2000), 1'b0, 1'b0,
                DECODE, 1'b0, 22'o1000, 22'o0,        11'd0, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[3]  = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b0, 1'b0,
                XFER,   1'b0, 22'o1001, 22'o2000,     11'd3, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 22'o7777, 1'b0, 36'd0,                     1'b1, 1'b0,
                XFER,   1'b0, 22'o1001, 22'o2001,     11'd2, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[5]  = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b1, 1'b0,
                XFER,   1'b0, 22'o1001, 22'o2002,     11'd1, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[6]  = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b1, 1'b0,
                XFER,   1'b0, 22'o1001, 22'o2003,     11'd0, 1'b1, 1'b0, 3'b000, 2'b00};
    tbl[7]  = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b0, 1'b0,
                FETCH,  1'b1, 22'o1001, 22'o2003,     11'd0, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[8]  = '{1'b0, 1'b0, 22'o0,    1'b1, ccw(3'd0, 11'd0, 22'o0),   1'b1, 1'b0,
                DECODE, 1'b0, 22'o1001, 22'o2003,     11'd0, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b0, 1'b0,
                IDLE,   1'b0, 22'o1001, 22'o2003,     11'd0, 1'b0, 1'b1, 3'b000, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 22'o4000, 1'b0, 36'd0,                     1'b0, 1'b0,
                FETCH,  1'b1, 22'o4000, 22'o2003,     11'd0, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[11] = '{1'b0, 1'b0, 22'o0,    1'b1, ccw(3'd7, 11'd2, 22'o0),   1'b0, 1'b0,
                DECODE, 1'b0, 22'o4000, 22'o2003,     11'd0, 1'b0, 1'b0, 3'b000, 2'b00};
    tbl[12] = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b0, 1'b0,
                XFER,   1'b0, 22'o4001, 22'o0,        11'd2, 1'b0, 1'b0, 3'b000, 2'b11};
    tbl[13] = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b1, 1'b0,
                XFER,   1'b0, 22'o4001, 22'o17777777, 11'd1, 1'b0, 1'b0, 3'b000, 2'b11};
    tbl[14] = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b1, 1'b0,
                XFER,   1'b0, 22'o4001, 22'o17777776, 11'd0, 1'b1, 1'b0, 3'b000, 2'b11};
    tbl[15] = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b0, 1'b0,
                XFER,   1'b0, 22'o4001, 22'o17777776, 11'd0, 1'b1, 1'b0, 3'b000, 2'b11};
    tbl[16] = '{1'b0, 1'b0, 22'o0,    1'b0, 36'd0,                     1'b0, 1'b1,
                IDLE,   1'b0, 22'o4001, 22'o17777776, 11'd0, 1'b0, 1'b1, 3'b000, 2'b11};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i], i);
    end

    // Jump to 0o3000 with the ack held off for 5 cycles.
    cyc(1'b0, 1'b1, 22'o5000, 1'b0, 36'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd2, 11'd0, 22'o3000), 1'b0, 1'b0);
    chk("jmp.decode", 64'(st), 64'(DECODE));
    idle_cyc();
    chk("jmp.refetch_state", 64'(st), 64'(FETCH));
    for (int k = 0; k < 5; k++) begin
      idle_cyc();
      chk($sformatf("jmp.wait%0d.req", k), 64'(mem_if.ccw_mem_req_h), 64'd1);
      chk($sformatf("jmp.wait%0d.adr", k), 64'(mem_if.ccw_mem_adr_h), 64'o3000);
      chk($sformatf("jmp.wait%0d.waiting", k), 64'(waiting), 64'd1);
    end
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd3, 11'd1, 22'o6000), 1'b0, 1'b0);
    idle_cyc();
    chk("jmp.data_state", 64'(st), 64'(XFER));
    chk("jmp.data_adr", 64'(data_adr), 64'o6000);
    chk("jmp.wc", 64'(wc), 64'd1);
    chk("jmp.last_rev", 64'({last, rev}), 64'b10);
    chk("jmp.ptr", 64'(mem_if.ccw_mem_adr_h), 64'o3001);
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b1, 1'b0);
    chk("jmp.wcEq0", 64'(eq0), 64'd1);
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b0, 1'b1);
    chk("jmp.done", 64'({st, done, short_err, long_err}), 64'({IDLE, 3'b100}));

    // Short word count: device ends after one of two words.
    cyc(1'b0, 1'b1, 22'o7000, 1'b0, 36'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd3, 11'd2, 22'o100), 1'b0, 1'b0);
    idle_cyc();
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b1, 1'b0);
    chk("short.wc", 64'(wc), 64'd1);
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b0, 1'b1);
    chk("short.flags", 64'({st, done, short_err, long_err}), 64'({IDLE, 3'b110}));

    // Long word count: third transfer on a 2-word CCW.
    cyc(1'b0, 1'b1, 22'o7000, 1'b0, 36'd0, 1'b0, 1'b0);
    chk("long.start_clears", 64'({done, short_err, long_err}), 64'b000);
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd3, 11'd2, 22'o100), 1'b0, 1'b0);
    idle_cyc();
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b1, 1'b0);
    chk("long.pre_err", 64'(long_err), 64'd0);
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b1, 1'b0);
    chk("long.err", 64'(long_err), 64'd1);
    chk("long.wc_held", 64'(wc), 64'd0);
    chk("long.adr_held", 64'(data_adr), 64'o102);
    chk("long.state", 64'(st), 64'(XFER));
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b0, 1'b1);
    chk("long.end", 64'({st, done, short_err, long_err}), 64'({IDLE, 3'b101}));

    // Reset during FETCH while an ack arrives.
    cyc(1'b0, 1'b1, 22'o1000, 1'b0, 36'd0, 1'b0, 1'b0);
    chk("rst.fetch", 64'(st), 64'(FETCH));
    cyc(1'b1, 1'b0, 22'o0, 1'b1, ccw(3'd1, 11'd5, 22'o2222), 1'b0, 1'b0);
    chk("rst.outs", 64'({st, mem_if.ccw_mem_req_h, mem_if.ccw_mem_adr_h, data_adr, wc, eq0,
                         last, rev, xv, waiting, done, short_err, long_err, jump_err}), 64'd0);
    idle_cyc();
    chk("rst.no_latch", 64'({st, data_adr, wc}), 64'd0);
    cyc(1'b0, 1'b1, 22'o1000, 1'b0, 36'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd1, 11'd1, 22'o2500), 1'b0, 1'b0);
    idle_cyc();
    chk("rst.rerun_load", 64'({st, data_adr, wc}), 64'({XFER, 22'o2500, 11'd1}));
    cyc(1'b0, 1'b0, 22'o0, 1'b0, 36'd0, 1'b1, 1'b0);
    idle_cyc();
    chk("rst.rerun_chain", 64'({st, mem_if.ccw_mem_adr_h}), 64'({FETCH, 22'o1001}));
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd0, 11'd0, 22'o0), 1'b0, 1'b0);
    idle_cyc();
    chk("rst.rerun_done", 64'({st, done}), 64'({IDLE, 1'b1}));

    // Three chained jumps.
    cyc(1'b0, 1'b1, 22'o100, 1'b0, 36'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd2, 11'd0, 22'o200), 1'b0, 1'b0);
    idle_cyc();
    chk("jl.fetch2", 64'({st, mem_if.ccw_mem_adr_h}), 64'({FETCH, 22'o200}));
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd2, 11'd0, 22'o300), 1'b0, 1'b0);
    idle_cyc();
    chk("jl.fetch3", 64'({st, mem_if.ccw_mem_adr_h}), 64'({FETCH, 22'o300}));
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd2, 11'd0, 22'o400), 1'b0, 1'b0);
    idle_cyc();
`ifdef CCW_JUMP_LIMIT_EN
    chk("jl.err", 64'({st, mem_if.ccw_mem_req_h, jump_err, done}), 64'({IDLE, 3'b011}));
    idle_cyc();
    chk("jl.no_fetch4", 64'(mem_if.ccw_mem_req_h), 64'd0);
`else
    chk("jl.fetch4", 64'({st, mem_if.ccw_mem_req_h, mem_if.ccw_mem_adr_h}),
        64'({FETCH, 1'b1, 22'o400}));
    chk("jl.no_err", 64'({jump_err, done}), 64'd0);
    cyc(1'b0, 1'b0, 22'o0, 1'b1, ccw(3'd0, 11'd0, 22'o0), 1'b0, 1'b0);
    idle_cyc();
    chk("jl.halt", 64'({st, done, jump_err}), 64'({IDLE, 2'b10}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
